key_pulse_gen: RTL and testbench

//  Front end for the decimal-key accumulator. Takes 10 raw push-button lines (keys 0..9),

---
 rtl/key_pulse_gen.sv | 120 ++++++++++++
 tb/tb_key_pulse_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - debounced ten-key front end producing one-hot Dec pulses
module key_pulse_gen #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [9:0] Key,
   output logic [9:0] Dec,
   output logic       Busy,
   output logic       Err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [9:0]       cand;
   logic [9:0]       key_m;
   logic [9:0]       key_s;
   logic             key_zero;
   logic             key_one_hot;

   // two-stage synchroniser; cleared by reset so a held key re-enters as a fresh press
   always_ff @(posedge CLK) begin
      if (RST) begin
         key_m <= '0;
         key_s <= '0;
      end else begin
         key_m <= Key;
         key_s <= key_m;
      end
   end

   // classify the synchronised key vector
   always_comb begin
      key_zero    = (key_s == 10'd0);
      key_one_hot = !key_zero && ((key_s & (key_s - 10'd1)) == 10'd0);
   end

   // press/release FSM with registered Dec, Busy and Err
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
         Dec   <= '0;
         Busy  <= 1'b0;
         Err   <= 1'b0;
      end else begin
         Dec <= '0;
         Err <= 1'b0;
         case (state)
            IDLE: begin
               if (key_one_hot) begin
                  cand  <= key_s;
                  cnt   <= CNT_W'(1);
                  state <= DEBOUNCE;
                  Busy  <= 1'b1;
               end else if (!key_zero) begin
                  Err   <= 1'b1;
                  cnt   <= '0;
                  state <= RELEASE;
                  Busy  <= 1'b1;
               end
            end
            DEBOUNCE: begin
               if (key_s == cand) begin
                  if (cnt == CNT_LAST) begin
                     Dec   <= cand;
                     state <= HELD;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (key_zero) begin
                  // short bounce: drop it silently
                  state <= IDLE;
                  Busy  <= 1'b0;
               end else begin
                  Err   <= 1'b1;
                  cnt   <= '0;
                  state <= RELEASE;
               end
            end
            HELD: begin
               // any change after acceptance, including an extra key, just waits for release
               if (key_s != cand) begin
                  cnt   <= '0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (key_zero) begin
                  if (cnt == CNT_LAST) begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - directed self-checking bench for key_pulse_gen
module tb_key_pulse_gen;

   logic       clk;
   logic       rst;
   logic [9:0] key;
   logic [9:0] dec;
   logic       busy;
   logic       err;

   int checks;
   int failures;
   int dec_count;
   int err_count;
   int multi_hot;
   logic [9:0] last_dec;

   key_pulse_gen #(.DEB_CYCLES(4), .CNT_W(3)) dut (
      .CLK  (clk),
      .RST  (rst),
      .Key  (key),
      .Dec  (dec),
      .Busy (busy),
      .Err  (err)
   );

   initial clk = 1'b0;
   always #100 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (dec != 10'd0) begin
         dec_count++;
         last_dec = dec;
      end
      if ((dec & (dec - 10'd1)) != 10'd0) multi_hot++;
      if (err) err_count++;
   endtask

   task automatic clear_counts();
      dec_count = 0;
      err_count = 0;
      last_dec  = 10'd0;
   endtask

   task automatic settle();
      key = 10'd0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key = 10'b0000100100;
      repeat (3) tick();
      checks++;
      if (dec !== 10'd0) begin
         failures++;
         $display("FAIL reset_dec got=%b exp=%b", dec, 10'd0);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b exp=0", err);
      end
      key = 10'd0;
      rst = 1'b0;
      settle();
   endtask

   task automatic test_single_press();
      clear_counts();
      key = 10'b0000001000;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL press_busy_e1 got=%b exp=0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL press_busy_e2 got=%b exp=1", busy);
      end
      repeat (2) tick();
      checks++;
      if (dec !== 10'd0) begin
         failures++;
         $display("FAIL press_dec_e4 got=%b exp=%b", dec, 10'd0);
      end
      tick();
      checks++;
      if (dec !== 10'b0000001000) begin
         failures++;
         $display("FAIL press_dec_e5 got=%b exp=%b", dec, 10'b0000001000);
      end
      tick();
      checks++;
      if (dec !== 10'd0) begin
         failures++;
         $display("FAIL press_dec_e6 got=%b exp=%b", dec, 10'd0);
      end
      repeat (3) tick();
      key = 10'd0;
      repeat (6) tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL release_busy_e15 got=%b exp=1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL release_busy_e16 got=%b exp=0", busy);
      end
      checks++;
      if (dec_count !== 1) begin
         failures++;
         $display("FAIL press_dec_count got=%0d exp=1", dec_count);
      end
      settle();
   endtask

   task automatic test_bounce();
      clear_counts();
      key = 10'b0000010000;
      repeat (2) tick();
      key = 10'd0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL bounce_busy_e3 got=%b exp=1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL bounce_busy_e4 got=%b exp=0", busy);
      end
      repeat (8) tick();
      checks++;
      if (dec_count !== 0 || err_count !== 0) begin
         failures++;
         $display("FAIL bounce_pulses got=dec%0d/err%0d exp=dec0/err0", dec_count, err_count);
      end
      settle();
   endtask

   task automatic test_multi_key();
      clear_counts();
      key = 10'b0001100000;
      repeat (3) tick();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL multi_err_e2 got=%b exp=1", err);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL multi_err_e3 got=%b exp=0", err);
      end
      repeat (2) tick();
      key = 10'd0;
      repeat (10) tick();
      checks++;
      if (err_count !== 1 || dec_count !== 0) begin
         failures++;
         $display("FAIL multi_pulses got=dec%0d/err%0d exp=dec0/err1", dec_count, err_count);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL multi_busy_idle got=%b exp=0", busy);
      end
      key = 10'b0000000100;
      repeat (5) tick();
      checks++;
      if (dec !== 10'd0) begin
         failures++;
         $display("FAIL after_multi_dec_e4 got=%b exp=%b", dec, 10'd0);
      end
      tick();
      checks++;
      if (dec !== 10'b0000000100) begin
         failures++;
         $display("FAIL after_multi_dec_e5 got=%b exp=%b", dec, 10'b0000000100);
      end
      settle();
   endtask

   task automatic test_extra_key_while_held();
      clear_counts();
      key = 10'b0000001000;
      repeat (10) tick();
      key = 10'b0000101000;
      repeat (10) tick();
      key = 10'd0;
      repeat (10) tick();
      checks++;
      if (dec_count !== 1 || last_dec !== 10'b0000001000) begin
         failures++;
         $display("FAIL held_extra_dec got=%0d/%b exp=1/%b", dec_count, last_dec, 10'b0000001000);
      end
      checks++;
      if (err_count !== 0) begin
         failures++;
         $display("FAIL held_extra_err got=%0d exp=0", err_count);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL held_extra_busy got=%b exp=0", busy);
      end
      settle();
   endtask

   task automatic test_back_to_back();
      clear_counts();
      key = 10'b0000010000;
      repeat (8) tick();
      key = 10'd0;
      repeat (2) tick();
      key = 10'b0000010000;
      repeat (8) tick();
      checks++;
      if (dec_count !== 1) begin
         failures++;
         $display("FAIL repress_no_second_dec got=%0d exp=1", dec_count);
      end
      key = 10'd0;
      repeat (10) tick();
      checks++;
      if (busy !== 1'b0 || dec_count !== 1) begin
         failures++;
         $display("FAIL repress_release got=busy%b/dec%0d exp=busy0/dec1", busy, dec_count);
      end
      key = 10'b0000010000;
      repeat (8) tick();
      checks++;
      if (dec_count !== 2 || last_dec !== 10'b0000010000) begin
         failures++;
         $display("FAIL repress_new_press got=%0d/%b exp=2/%b", dec_count, last_dec, 10'b0000010000);
      end
      settle();
   endtask

   task automatic test_reset_mid_debounce();
      clear_counts();
      key = 10'b0001000000;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy_before got=%b exp=1", busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (dec !== 10'd0 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs got=%b/%b/%b exp=0/0/0", dec, busy, err);
      end
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_busy_e1 got=%b exp=0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy_e2 got=%b exp=1", busy);
      end
      repeat (2) tick();
      checks++;
      if (dec !== 10'd0) begin
         failures++;
         $display("FAIL rst_mid_dec_e4 got=%b exp=%b", dec, 10'd0);
      end
      tick();
      checks++;
      if (dec !== 10'b0001000000) begin
         failures++;
         $display("FAIL rst_mid_dec_e5 got=%b exp=%b", dec, 10'b0001000000);
      end
      settle();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      multi_hot = 0;
      rst       = 1'b1;
      key       = 10'd0;
      clear_counts();
      test_reset();
      test_single_press();
      test_bounce();
      test_multi_key();
      test_extra_key_while_held();
      test_back_to_back();
      test_reset_mid_debounce();
      checks++;
      if (multi_hot !== 0) begin
         failures++;
         $display("FAIL dec_one_hot got=%0d multi-hot cycles exp=0", multi_hot);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
